// File: rtl/cr_huf_comp_st_reader_pkg.sv
// Shared types for the Huffman compressor symbol-table path: queue entry layout,
// end-of-block encoding, and the symbol-table reader's state and output beat.
package cr_huf_compPKG;

  localparam int CREOLE_HC_ST_SYMB_WIDTH            = 10;
  localparam int CREOLE_HC_SEQID_WIDTH              = 8;
  localparam int CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE = 12;

  typedef enum logic [1:0] {
    MIDDLE      = 2'd0,
    PASS_THRU   = 2'd1,
    MORE_COMING = 2'd2,
    EOB         = 2'd3
  } e_pipe_eob;

  typedef struct packed {
    logic [7:0]                         extra;
    logic [3:0]                         extra_length;
    logic [CREOLE_HC_ST_SYMB_WIDTH-1:0] symbol;
    logic                               val;
  } s_st_sym_buf_intf;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WALK     = 3'd1,
    TRAIL    = 3'd2,
    DONE     = 3'd3,
    WAIT_CLR = 3'd4
  } e_st_rd_state;

  typedef struct packed {
    logic                               eot;
    logic [CREOLE_HC_ST_SYMB_WIDTH-1:0] symbol;
    logic [7:0]                         extra;
    logic [3:0]                         extra_length;
    logic [CREOLE_HC_SEQID_WIDTH-1:0]   seq_id;
    e_pipe_eob                          eob;
    logic                               error;
  } s_st_rd_out;

  localparam s_st_rd_out ST_RD_OUT_RST = '{
    eot:          1'b0,
    symbol:       '0,
    extra:        '0,
    extra_length: '0,
    seq_id:       '0,
    eob:          MIDDLE,
    error:        1'b0
  };

endpackage

// File: rtl/cr_huf_comp_st_reader.sv
// Walks a captured symbol table, streams its valid entries downstream, then sends a trailer
// and releases the queue. Define CR_HUF_COMP_ST_READER_XTR_CHK_EN to flag extra-bit total mismatches.
module cr_huf_comp_st_reader
  import cr_huf_compPKG::*;
#(
  parameter  int MAX_SYMBOL_TABLE_DEPTH = 584,
  localparam int PtrW = $clog2(MAX_SYMBOL_TABLE_DEPTH + 1),
  localparam int XtrW = CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sym_buf_full_i,
  input  logic [PtrW-1:0]                    sym_buf_wr_ptr_i,
  input  s_st_sym_buf_intf                   sym_buf_i [MAX_SYMBOL_TABLE_DEPTH],
  input  logic [XtrW-1:0]                    st_extra_size_store_i,
  input  logic [CREOLE_HC_SEQID_WIDTH-1:0]   st_seq_id_i,
  input  e_pipe_eob                          st_eob_i,
  input  logic                               st_build_error_i,
  input  logic                               st_out_rdy_i,
  output logic                               st_out_val_o,
  output logic                               st_out_eot_o,
  output logic [CREOLE_HC_ST_SYMB_WIDTH-1:0] st_out_symbol_o,
  output logic [7:0]                         st_out_extra_o,
  output logic [3:0]                         st_out_extra_length_o,
  output logic [CREOLE_HC_SEQID_WIDTH-1:0]   st_out_seq_id_o,
  output e_pipe_eob                          st_out_eob_o,
  output logic                               st_out_error_o,
  output logic                               sa_st_read_done_o
);

  e_st_rd_state     state_q;
  logic [PtrW-1:0]  idx_q;
  logic             outVal_q;
  s_st_rd_out       outBeat_q;
  logic             readDone_q;

  s_st_sym_buf_intf curEntry;
  logic             outFree;
  logic             trailError;

  assign curEntry = sym_buf_i[idx_q];
  assign outFree  = !outVal_q || st_out_rdy_i;

`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
  logic [XtrW-1:0] xtrSum_q;
  logic [XtrW-1:0] xtrSum_d;
  logic [XtrW:0]   xtrSumWide;

  // Saturating accumulate so a corrupt table cannot wrap back to a matching total.
  assign xtrSumWide = {1'b0, xtrSum_q} + (XtrW + 1)'(curEntry.extra_length);
  assign xtrSum_d   = xtrSumWide[XtrW] ? '1 : xtrSumWide[XtrW-1:0];
  assign trailError = st_build_error_i | (xtrSum_q != st_extra_size_store_i);
`else
  logic unusedXtrStore;

  assign unusedXtrStore = ^st_extra_size_store_i;
  assign trailError     = st_build_error_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      outVal_q   <= 1'b0;
      outBeat_q  <= ST_RD_OUT_RST;
      readDone_q <= 1'b0;
`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
      xtrSum_q   <= '0;
`endif
    end else begin
      readDone_q <= 1'b0;
      if (outVal_q && st_out_rdy_i) outVal_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (sym_buf_full_i) begin
            outBeat_q        <= ST_RD_OUT_RST;
            outBeat_q.seq_id <= st_seq_id_i;
            idx_q            <= '0;
`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
            xtrSum_q         <= '0;
`endif
            state_q          <= st_build_error_i ? TRAIL : WALK;
          end
        end
        WALK: begin
          if (outFree) begin
            if (idx_q < sym_buf_wr_ptr_i) begin
              idx_q <= idx_q + PtrW'(1);
              if (curEntry.val) begin
                outVal_q               <= 1'b1;
                outBeat_q.symbol       <= curEntry.symbol;
                outBeat_q.extra        <= curEntry.extra;
                outBeat_q.extra_length <= curEntry.extra_length;
`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
                xtrSum_q               <= xtrSum_d;
`endif
              end
            end else begin
              state_q <= TRAIL;
            end
          end
        end
        TRAIL: begin
          // The eot flag tells an already-launched trailer apart from a last data beat still draining.
          if (outVal_q && outBeat_q.eot) begin
            if (st_out_rdy_i) begin
              state_q    <= DONE;
              readDone_q <= 1'b1;
            end
          end else if (outFree) begin
            outVal_q               <= 1'b1;
            outBeat_q.eot          <= 1'b1;
            outBeat_q.symbol       <= '0;
            outBeat_q.extra        <= '0;
            outBeat_q.extra_length <= '0;
            outBeat_q.eob          <= st_eob_i;
            outBeat_q.error        <= trailError;
          end
        end
        DONE: begin
          state_q <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!sym_buf_full_i) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign st_out_val_o          = outVal_q;
  assign st_out_eot_o          = outBeat_q.eot;
  assign st_out_symbol_o       = outBeat_q.symbol;
  assign st_out_extra_o        = outBeat_q.extra;
  assign st_out_extra_length_o = outBeat_q.extra_length;
  assign st_out_seq_id_o       = outBeat_q.seq_id;
  assign st_out_eob_o          = outBeat_q.eob;
  assign st_out_error_o        = outBeat_q.error;
  assign sa_st_read_done_o     = readDone_q;

endmodule

// File: tb/tb_cr_huf_comp_st_reader.sv
// Directed bench for cr_huf_comp_st_reader: table walks, empty and failed tables,
// backpressure, extra-bit check and mid-walk reset.
module tb_cr_huf_comp_st_reader;
  import cr_huf_compPKG::*;

  localparam int Depth = 584;
  localparam int PtrW  = $clog2(Depth + 1);
  localparam int XtrW  = CREOLE_HC_SMALL_TABLE_XTR_BIT_SIZE + 1;

  logic                               clk = 1'b0;
  logic                               rstN;
  logic                               symBufFull;
  logic [PtrW-1:0]                    wrPtr;
  s_st_sym_buf_intf                   symBuf [Depth];
  logic [XtrW-1:0]                    extraSizeStore;
  logic [CREOLE_HC_SEQID_WIDTH-1:0]   seqId;
  e_pipe_eob                          eobIn;
  logic                               buildError;
  logic                               outRdy;
  logic                               outVal;
  logic                               outEot;
  logic [CREOLE_HC_ST_SYMB_WIDTH-1:0] outSymbol;
  logic [7:0]                         outExtra;
  logic [3:0]                         outXl;
  logic [CREOLE_HC_SEQID_WIDTH-1:0]   outSeqId;
  e_pipe_eob                          outEob;
  logic                               outError;
  logic                               readDone;

  typedef struct {
    logic                               eot;
    logic [CREOLE_HC_ST_SYMB_WIDTH-1:0] symbol;
    logic [7:0]                         extra;
    logic [3:0]                         xl;
    logic                               err;
    e_pipe_eob                          eob;
    int                                 cyc;
  } beat_t;

  beat_t beats[$];
  int    doneCount   = 0;
  int    doneCycle   = 0;
  int    cycleCnt    = 0;
  int    startCycle  = 0;
  int    assertCount = 0;
  int    failCount   = 0;
  logic  expXtrErr;

  cr_huf_comp_st_reader #(.MAX_SYMBOL_TABLE_DEPTH(Depth)) dut (
    .clk                   (clk),
    .rst_n                 (rstN),
    .sym_buf_full_i        (symBufFull),
    .sym_buf_wr_ptr_i      (wrPtr),
    .sym_buf_i             (symBuf),
    .st_extra_size_store_i (extraSizeStore),
    .st_seq_id_i           (seqId),
    .st_eob_i              (eobIn),
    .st_build_error_i      (buildError),
    .st_out_rdy_i          (outRdy),
    .st_out_val_o          (outVal),
    .st_out_eot_o          (outEot),
    .st_out_symbol_o       (outSymbol),
    .st_out_extra_o        (outExtra),
    .st_out_extra_length_o (outXl),
    .st_out_seq_id_o       (outSeqId),
    .st_out_eob_o          (outEob),
    .st_out_error_o        (outError),
    .sa_st_read_done_o     (readDone)
  );

  always #5 clk = ~clk;

  // Monitor samples just before each rising edge, logging accepted beats and done pulses.
  always begin
    @(negedge clk);
    #4;
    if (rstN && outVal && outRdy)
      beats.push_back('{outEot, outSymbol, outExtra, outXl, outError, outEob, cycleCnt});
    if (readDone) begin
      doneCount++;
      doneCycle = cycleCnt;
    end
    cycleCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t beatAt(input int i);
    beat_t b;
    b = '{1'b0, '0, '0, '0, 1'b0, MIDDLE, -1};
    if (i < beats.size()) b = beats[i];
    return b;
  endfunction

  task automatic clearBuf();
    for (int i = 0; i < Depth; i++) symBuf[i] = '0;
  endtask

  task automatic setEntry(input int i, input int sym, input logic v, input int xl, input int ex);
    symBuf[i] = '{extra: ex[7:0], extra_length: xl[3:0], symbol: sym[CREOLE_HC_ST_SYMB_WIDTH-1:0], val: v};
  endtask

  task automatic applyStimulus(input int wp, input logic bErr, input int seq, input int store, input e_pipe_eob eob);
    @(negedge clk);
    beats.delete();
    doneCount      = 0;
    wrPtr          = wp[PtrW-1:0];
    buildError     = bErr;
    seqId          = seq[CREOLE_HC_SEQID_WIDTH-1:0];
    extraSizeStore = store[XtrW-1:0];
    eobIn          = eob;
    startCycle     = cycleCnt;
    symBufFull     = 1'b1;
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles && doneCount == 0; i++) @(negedge clk);
    checkOutput({tag, "_done_seen"}, doneCount != 0, 1);
  endtask

  // Holding full high after release must not start a second walk.
  task automatic releaseTable(input string tag);
    int nBeats;
    nBeats = beats.size();
    repeat (4) @(negedge clk);
    checkOutput({tag, "_no_retrig"}, beats.size(), nBeats);
    checkOutput({tag, "_done_once"}, doneCount, 1);
    symBufFull = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic rdyPat [4];
    logic stalled;
    logic [CREOLE_HC_ST_SYMB_WIDTH-1:0] savedSym;
    logic [3:0] savedXl;
    int k;
    int stallCount;

    rdyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rstN = 1'b0; symBufFull = 1'b0; wrPtr = '0; extraSizeStore = '0; seqId = '0;
    eobIn = MIDDLE; buildError = 1'b0; outRdy = 1'b1;
    clearBuf();
    repeat (3) @(negedge clk);
    checkOutput("rst_val", outVal, 0);
    checkOutput("rst_eot", outEot, 0);
    checkOutput("rst_eob", outEob, MIDDLE);
    checkOutput("rst_done", readDone, 0);
    checkOutput("rst_seq", outSeqId, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Two valid entries around a hole, extra total matches.
    clearBuf();
    setEntry(0, 10, 1'b1, 2, 3);
    setEntry(1, 11, 1'b0, 1, 1);
    setEntry(2, 12, 1'b1, 3, 5);
    applyStimulus(3, 1'b0, 5, 5, EOB);
    waitDone("t1", 30);
    checkOutput("t1_nbeats", beats.size(), 3);
    checkOutput("t1_b0_sym", beatAt(0).symbol, 10);
    checkOutput("t1_b0_extra", beatAt(0).extra, 3);
    checkOutput("t1_b0_xl", beatAt(0).xl, 2);
    checkOutput("t1_b0_eot", beatAt(0).eot, 0);
    checkOutput("t1_latency", beatAt(0).cyc, startCycle + 2);
    checkOutput("t1_b1_sym", beatAt(1).symbol, 12);
    checkOutput("t1_b1_xl", beatAt(1).xl, 3);
    checkOutput("t1_trl_eot", beatAt(2).eot, 1);
    checkOutput("t1_trl_sym", beatAt(2).symbol, 0);
    checkOutput("t1_trl_eob", beatAt(2).eob, EOB);
    checkOutput("t1_trl_err", beatAt(2).err, 0);
    checkOutput("t1_seq", outSeqId, 5);
    checkOutput("t1_done_cyc", doneCycle, beatAt(2).cyc + 1);
    releaseTable("t1");

    // Empty table sends only the trailer.
    applyStimulus(0, 1'b0, 7, 0, PASS_THRU);
    waitDone("t2", 20);
    checkOutput("t2_nbeats", beats.size(), 1);
    checkOutput("t2_trl_eot", beatAt(0).eot, 1);
    checkOutput("t2_trl_eob", beatAt(0).eob, PASS_THRU);
    checkOutput("t2_done_cyc", doneCycle, beatAt(0).cyc + 1);
    checkOutput("t2_seq", outSeqId, 7);
    releaseTable("t2");

    // Failed build skips the walk entirely.
    clearBuf();
    for (int i = 0; i < 5; i++) setEntry(i, 50 + i, 1'b1, 1, 1);
    applyStimulus(5, 1'b1, 9, 5, EOB);
    waitDone("t3", 20);
    checkOutput("t3_nbeats", beats.size(), 1);
    checkOutput("t3_trl_eot", beatAt(0).eot, 1);
    checkOutput("t3_trl_err", beatAt(0).err, 1);
    buildError = 1'b0;
    releaseTable("t3");

    // Backpressure: rdy 1,0,0,1 once beats start flowing.
    clearBuf();
    for (int i = 0; i < 4; i++) setEntry(i, 20 + i, 1'b1, 1, i);
    applyStimulus(4, 1'b0, 3, 4, MORE_COMING);
    stalled = 1'b0; k = -1; stallCount = 0; savedSym = '0; savedXl = '0;
    for (int c = 0; c < 60 && doneCount == 0; c++) begin
      @(negedge clk);
      if (stalled) begin
        stallCount++;
        checkOutput("t4_stall_val", outVal, 1);
        checkOutput("t4_stall_sym", outSymbol, savedSym);
        checkOutput("t4_stall_xl", outXl, savedXl);
      end
      if (k < 0 && outVal) k = 0;
      if (k >= 0 && k < 4) begin
        outRdy = rdyPat[k];
        k++;
      end else begin
        outRdy = 1'b1;
      end
      stalled  = outVal && !outRdy;
      savedSym = outSymbol;
      savedXl  = outXl;
    end
    outRdy = 1'b1;
    waitDone("t4", 10);
    checkOutput("t4_stalls", stallCount, 2);
    checkOutput("t4_nbeats", beats.size(), 5);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t4_b%0d_sym", i), beatAt(i).symbol, 20 + i);
    checkOutput("t4_trl_eot", beatAt(4).eot, 1);
    checkOutput("t4_trl_err", beatAt(4).err, 0);
    releaseTable("t4");

    // Extra-bit total 5 against stored 6.
`ifdef CR_HUF_COMP_ST_READER_XTR_CHK_EN
    expXtrErr = 1'b1;
`else
    expXtrErr = 1'b0;
`endif
    clearBuf();
    setEntry(0, 40, 1'b1, 2, 1);
    setEntry(1, 41, 1'b1, 3, 2);
    applyStimulus(2, 1'b0, 4, 6, EOB);
    waitDone("t5", 20);
    checkOutput("t5_nbeats", beats.size(), 3);
    checkOutput("t5_trl_err", beatAt(2).err, expXtrErr);
    releaseTable("t5");

    // Reset two cycles mid-walk with full still high; walk must restart at entry 0.
    clearBuf();
    for (int i = 0; i < 4; i++) setEntry(i, 30 + i, 1'b1, 1, 0);
    applyStimulus(4, 1'b0, 6, 4, EOB);
    for (int i = 0; i < 20 && beats.size() < 2; i++) @(negedge clk);
    checkOutput("t6_walk_started", beats.size() >= 2, 1);
    rstN = 1'b0;
    beats.delete();
    doneCount = 0;
    @(negedge clk);
    checkOutput("t6_rst_val", outVal, 0);
    checkOutput("t6_rst_sym", outSymbol, 0);
    @(negedge clk);
    checkOutput("t6_rst_seq", outSeqId, 0);
    checkOutput("t6_rst_done", readDone, 0);
    checkOutput("t6_rst_eob", outEob, MIDDLE);
    checkOutput("t6_rst_nodone", doneCount, 0);
    rstN = 1'b1;
    waitDone("t6", 30);
    checkOutput("t6_nbeats", beats.size(), 5);
    checkOutput("t6_b0_sym", beatAt(0).symbol, 30);
    checkOutput("t6_b3_sym", beatAt(3).symbol, 33);
    checkOutput("t6_trl_eot", beatAt(4).eot, 1);
    checkOutput("t6_seq", outSeqId, 6);
    releaseTable("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
